// File: rtl/univ_shift_register_seq.sv
// Multi-cycle universal shift register: load, logical/arithmetic shift and rotate
// by a requested amount, one bit position per clock, with start/busy/done handshake.
module univ_shift_register_seq #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [AW-1:0] amt,
  input  logic [N-1:0]  d,
  input  logic          msb_in,
  input  logic          lsb_in,
  output logic [N-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic          serial_out
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_SRL  = 3'b001,
    OP_SLL  = 3'b010,
    OP_SRA  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_NOP6 = 3'b110,
    OP_NOP7 = 3'b111
  } op_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_q, q_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          so_q, so_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    so_d    = so_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_e'(mode))
            OP_LOAD: begin
              q_d    = d;
              done_d = 1'b1;
            end
            OP_SRL, OP_SLL, OP_SRA, OP_ROR, OP_ROL: begin
              // A zero count completes like a no-op without entering SHIFT
              if (amt == '0) begin
                done_d = 1'b1;
              end else begin
                op_d    = op_e'(mode);
                cnt_d   = amt;
                state_d = SHIFT;
                busy_d  = 1'b1;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end

      SHIFT: begin
        case (op_q)
          OP_SRL: begin
            q_d  = {msb_in, q_q[N-1:1]};
            so_d = q_q[0];
          end
          OP_SLL: begin
            q_d  = {q_q[N-2:0], lsb_in};
            so_d = q_q[N-1];
          end
          OP_SRA: begin
            q_d  = {q_q[N-1], q_q[N-1:1]};
            so_d = q_q[0];
          end
          OP_ROR: begin
            q_d  = {q_q[0], q_q[N-1:1]};
            so_d = q_q[0];
          end
          OP_ROL: begin
            q_d  = {q_q[N-2:0], q_q[N-1]};
            so_d = q_q[N-1];
          end
          default: ;
        endcase
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      so_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      so_q    <= so_d;
    end
  end

  assign q          = q_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign serial_out = so_q;

endmodule

// File: tb/tb_univ_shift_register_seq.sv
// Self-checking bench for univ_shift_register_seq: directed vector table, reset abort
// sequence, and randomized operations checked against an arithmetic reference model.
module tb_univ_shift_register_seq;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] mode;
  logic [3:0] amt;
  logic [7:0] d;
  logic       msb_in;
  logic       lsb_in;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       serial_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_model;
  logic       so_model;

  univ_shift_register_seq #(.N(8), .AW(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .mode       (mode),
    .amt        (amt),
    .d          (d),
    .msb_in     (msb_in),
    .lsb_in     (lsb_in),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .serial_out (serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] d;
    logic       fill;
    bit         spur;
    logic [7:0] exp_q;
    logic       exp_so;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Result of k single-bit steps computed as one wide shift/rotate; f[i] is the
  // serial bit presented at step i.
  task automatic model(input logic [7:0] qi, input logic [2:0] md, input int k,
                       input logic [15:0] f, output logic [7:0] qo, output logic so);
    logic [63:0] l;
    logic [63:0] l2;
    logic [15:0] dbl;
    int r;
    qo = qi;
    so = 1'b0;
    dbl = {qi, qi};
    r = k % 8;
    case (md)
      3'b001, 3'b011: begin
        l = {56'b0, qi};
        for (int i = 0; i < k; i++) l[8+i] = (md == 3'b011) ? qi[7] : f[i];
        l2 = l >> k;
        qo = l2[7:0];
        so = l[k-1];
      end
      3'b010: begin
        l = {56'b0, qi} << k;
        for (int i = 0; i < k; i++) l[k-1-i] = f[i];
        qo = l[7:0];
        so = l[8];
      end
      3'b100: begin
        dbl = dbl >> r;
        qo = dbl[7:0];
        so = qi[(k-1) % 8];
      end
      3'b101: begin
        dbl = dbl << r;
        qo = dbl[15:8];
        so = qi[7 - ((k-1) % 8)];
      end
      default: ;
    endcase
  endtask

  // Called just after a negedge; returns just after the negedge of the done cycle.
  task automatic run_op(input logic [2:0] md, input logic [3:0] am, input logic [7:0] dd,
                        input logic [15:0] f, input bit spur,
                        input logic [7:0] eq, input logic eso, input string nm);
    bit imm;
    imm = (md == 3'b000) || (md >= 3'b110) || (am == 4'd0);
    mode  = md;
    amt   = am;
    d     = dd;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (!imm) begin
      for (int i = 0; i < int'(am); i++) begin
        chk({nm, " busy"}, busy, 1'b1);
        chk({nm, " done_early"}, done, 1'b0);
        if (md == 3'b010) begin
          lsb_in = f[i];
          msb_in = 1'($urandom);
        end else begin
          msb_in = f[i];
          lsb_in = 1'($urandom);
        end
        d    = 8'($urandom);
        mode = 3'($urandom);
        amt  = 4'($urandom);
        if (spur && i == 2) begin
          mode  = 3'b000;
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
      end
      start = 1'b0;
    end
    chk({nm, " done"}, done, 1'b1);
    chk({nm, " busy_at_done"}, busy, 1'b0);
    chk({nm, " q"}, q, eq);
    chk({nm, " serial_out"}, serial_out, eso);
    q_model  = eq;
    so_model = eso;
  endtask

  task automatic idle_cycle(input string nm);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " done_single"}, done, 1'b0);
    chk({nm, " busy_idle"}, busy, 1'b0);
  endtask

  vec_t vecs[14];

  initial begin
    logic [7:0]  eq;
    logic        eso;
    logic [15:0] f;
    logic [2:0]  md;
    logic [3:0]  am;
    logic [7:0]  dd;

    vecs[0]  = '{3'b000, 4'd0,  8'hB5, 1'b0, 1'b0, 8'hB5, 1'b0};
    vecs[1]  = '{3'b011, 4'd3,  8'h00, 1'b0, 1'b0, 8'hF6, 1'b1};
    vecs[2]  = '{3'b000, 4'd0,  8'h81, 1'b0, 1'b0, 8'h81, 1'b1};
    vecs[3]  = '{3'b101, 4'd10, 8'h00, 1'b0, 1'b1, 8'h06, 1'b0};
    vecs[4]  = '{3'b000, 4'd0,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{3'b010, 4'd4,  8'h00, 1'b1, 1'b0, 8'h0F, 1'b0};
    vecs[6]  = '{3'b000, 4'd0,  8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0};
    vecs[7]  = '{3'b001, 4'd0,  8'h00, 1'b1, 1'b0, 8'h3C, 1'b0};
    vecs[8]  = '{3'b111, 4'd5,  8'hAA, 1'b1, 1'b0, 8'h3C, 1'b0};
    vecs[9]  = '{3'b001, 4'd2,  8'h00, 1'b1, 1'b0, 8'hCF, 1'b0};
    vecs[10] = '{3'b000, 4'd0,  8'h96, 1'b0, 1'b0, 8'h96, 1'b0};
    vecs[11] = '{3'b100, 4'd9,  8'h00, 1'b0, 1'b0, 8'h4B, 1'b0};
    vecs[12] = '{3'b011, 4'd15, 8'h80, 1'b0, 1'b0, 8'hFF, 1'b1};
    vecs[13] = '{3'b010, 4'd12, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};

    reset_n = 1'b1;
    start   = 1'b0;
    mode    = '0;
    amt     = '0;
    d       = '0;
    msb_in  = 1'b0;
    lsb_in  = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("reset q", q, 8'h00);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset serial_out", serial_out, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    q_model = '0;
    so_model = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (i == 12) begin
        // SRA 15 starts from a freshly loaded 0x80
        run_op(3'b000, 4'd0, 8'h80, 16'h0, 1'b0, 8'h80, so_model, "vec_load80");
      end
      run_op(vecs[i].mode, vecs[i].amt, vecs[i].d, {16{vecs[i].fill}}, vecs[i].spur,
             vecs[i].exp_q, vecs[i].exp_so, $sformatf("vec%0d", i));
      if (i == 3 || i == 9) idle_cycle($sformatf("vec%0d", i));
      if (i == 5) begin
        // Repeat SLL 4 from zero, then abort with reset after two shifts
        run_op(3'b000, 4'd0, 8'h00, 16'h0, 1'b0, 8'h00, so_model, "abort_load");
        mode   = 3'b010;
        amt    = 4'd4;
        lsb_in = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("abort busy", busy, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort partial q", q, 8'h03);
        #2 reset_n = 1'b0;
        #1;
        chk("abort q", q, 8'h00);
        chk("abort busy_clr", busy, 1'b0);
        chk("abort done_clr", done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("abort no_done", done, 1'b0);
          chk("abort q_held", q, 8'h00);
        end
        q_model  = '0;
        so_model = 1'b0;
      end
    end

    for (int n = 0; n < 40; n++) begin
      md = 3'($urandom);
      am = 4'($urandom);
      dd = 8'($urandom);
      f  = 16'($urandom);
      if (md == 3'b000) begin
        eq  = dd;
        eso = so_model;
      end else if (md >= 3'b110 || am == 4'd0) begin
        eq  = q_model;
        eso = so_model;
      end else begin
        model(q_model, md, int'(am), f, eq, eso);
      end
      run_op(md, am, dd, f, ($urandom_range(0, 3) == 0), eq, eso, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 2) == 0) idle_cycle($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_register_seq.md
# univ_shift_register_seq

Parametrised, multi-cycle universal shift register with a start/busy/done handshake. It loads a word, or shifts or rotates it by a requested amount, one bit position per clock. Supported operations are logical, arithmetic and rotate shifts, with live serial inputs and a serial output. It is the controller-driven successor to the plain single-step universal shift register, for datapaths that need shift-by-k without a barrel shifter.

## Interface
- N, default 8: register width (N ≥ 2).
- AW, default 4: width of the shift-amount input.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy = 0.
- mode  in  3  operation code:
  - 000 load
  - 001 SRL (shift right, fill from msb_in)
  - 010 SLL (shift left, fill from lsb_in)
  - 011 SRA (shift right, replicate q[N-1])
  - 100 ROR
  - 101 ROL
  - 110/111 no-op
- amt  in  AW  shift count; sampled with start; ignored for load/no-op.
- d  in  N  parallel load data.
- msb_in  in  1  serial fill bit for SRL; sampled on every shift edge.
- lsb_in  in  1  serial fill bit for SLL; sampled on every shift edge.
- q  out  N  register contents.
- busy  out  1  high while shifts remain.
- done  out  1  one-cycle completion pulse.
- serial_out  out  1  last bit shifted or rotated out of q.

## Operation
- States are IDLE and SHIFT. Internal registers are op (3 bits) and cnt (AW bits).
- IDLE, start = 1, mode = 000: q ← d at that edge; done = 1 the next cycle; busy stays 0.
- IDLE, start = 1, mode = 110/111, or any shift mode with amt = 0: q unchanged; done = 1 the next cycle; busy stays 0.
- IDLE, start = 1, shift/rotate mode, amt = k > 0: latch op ← mode and cnt ← k; go to SHIFT; busy = 1.
- Each SHIFT edge performs one bit step:
  - SRL: q ← {msb_in, q[N-1:1]}
  - SLL: q ← {q[N-2:0], lsb_in}
  - SRA: q ← {q[N-1], q[N-1:1]}
  - ROR: q ← {q[0], q[N-1:1]}
  - ROL: q ← {q[N-2:0], q[N-1]}
- On the same edge, serial_out ← the bit leaving q (q[0] for right operations, q[N-1] for left operations), and cnt ← cnt − 1.
- When cnt = 1 on a SHIFT edge: perform the last step, go to IDLE, busy ← 0, done ← 1.
- amt > N is executed literally, bit by bit:
  - rotates wrap (ROL by N+2 equals ROL by 2);
  - SRL/SLL end fully filled with serial bits;
  - SRA ends all copies of the sign bit.
- start while busy = 1 is ignored. d, mode and amt changes during SHIFT have no effect.
- serial_out holds its value outside shift edges. Load and no-op do not change it.

## Timing
- Reset (reset_n = 0, asynchronous, any state): q = 0, busy = 0, done = 0, serial_out = 0, state = IDLE, cnt = 0. Outputs clear immediately, with no clock required.
- After reset_n rises, the first rising edge can accept start.
- Shift by k > 0, with start accepted at edge E0:
  - busy is high from after E0 through edge Ek;
  - the shifts occur at edges E1..Ek;
  - done is high for exactly one cycle after Ek, and q holds its final value in that cycle.
- Load, no-op and amt = 0: one-cycle latency; done is high in the cycle after the accepting edge.
- A new start may be asserted in the same cycle that done is high (busy = 0). This gives back-to-back operations with no gap.
- done and busy are never high in the same cycle.
- Reset mid-SHIFT aborts the operation. No done pulse is produced and the partial result is discarded (q = 0).

## Test plan
- Reset: drive reset_n low between clock edges during SHIFT → q = 00, busy = 0, done = 0 immediately. After reset_n rises, the next start is accepted normally.
- Load: start, mode 000, d = B5 → q = B5 one edge later; done pulses once; busy never high; serial_out stays 0.
- SRA: from q = B5, mode 011, amt = 3 → busy high 3 cycles; q goes D A, E D, F 6; done pulses with q = F6; serial_out = 1.
- ROL wrap with ignored start: from q = 81, mode 101, amt = 10; start is pulsed again with mode 000 during busy → the extra start is ignored; q = 06 after 10 shifts; done is a single pulse.
- SLL with reset abort: from q = 00, mode 010, amt = 4, lsb_in = 1 → q = 0F with done. Repeat the operation and assert reset after 2 shifts → q = 00 and no done pulse.
- Zero amount and no-op:
  - from q = 3C, mode 001, amt = 0 → q = 3C, done after one cycle, busy stays 0;
  - mode 111 → same behaviour;
  - immediately follow with start, mode 001, amt = 2, msb_in = 1 in the done cycle → q = CF.
